dvp_capture: RTL and testbench
==============================

# dvp_capture

Front-end of the DVP video path: samples an 8-bit DVP camera bus (VSYNC/HREF/D[7:0]) on the pixel clock, assembles byte pairs into RGB565 pixels, expands them to RGB888 and emits a `vs_o`/`de_o`/`rgb_o` stream. It sits directly upstream of the window-crop stage, which requires a vsync pulse at every frame start to reset its pixel/line counters. The block also discards the first frames after enable while the sensor settles, and flags malformed lines and frames.

## Interface
- `H_DISP`, 1280, expected pixels per line (href-high bytes / 2).
- `V_DISP`, 720, expected lines per frame.
- `SKIP_FRAMES`, 10, frames discarded after reset or re-enable (0 = none); 8-bit counter.
- `VS_POL`, 1, active level of `cam_vsync` (1 = high).

Ports:
- `clk` input 1: camera pixel clock (PCLK); all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous active-low.
- `cam_vsync` input 1: camera frame sync, polarity per `VS_POL`.
- `cam_href` input 1: camera line valid, active high.
- `cam_data` input 8: camera data byte.
- `enable` input 1: capture enable, sampled only at frame start.
- `vs_o` output 1: one-cycle frame-start pulse.
- `de_o` output 1: pixel valid, one cycle per pixel.
- `rgb_o` output 24: RGB888 pixel {R,G,B}; holds its last value when `de_o`=0.
- `frame_done` output 1: one-cycle pulse at the end of each forwarded frame.
- `err` output 2: sticky flags; bit0 = line length ≠ `H_DISP` or odd byte count, bit1 = line count ≠ `V_DISP`.

## Operation
- Input stage: `cam_vsync` (normalised by `VS_POL`), `cam_href` and `cam_data` are registered once (s1). All edge detection uses s1 and its delayed copy.
- Frame start is the rising edge of normalised vsync. At each frame start:
  - Latch `enable` into `run`.
  - Clear the line counter and the byte phase.
  - If `run`=0, reload `skip_cnt` to `SKIP_FRAMES`.
  - If `run`=1 and `skip_cnt`>0, decrement `skip_cnt`. That frame is still suppressed.
  - The frame is forwarded when `run`=1 and `skip_cnt`==0 after that update; this sets `fwd`.
- States: IDLE (`run`=0), SKIP (`run`=1, `skip_cnt`>0), STREAM (`fwd`=1). Transitions happen only at a frame start.
- Byte phase toggles on each s1 byte with href high:
  - Phase 0 stores the byte as hi[7:0].
  - Phase 1 forms `pix` = {hi, byte}.
- RGB expansion:
  - R = {pix[15:11], pix[15:13]}
  - G = {pix[10:5], pix[10:9]}
  - B = {pix[4:0], pix[4:2]}
- `de_o` pulses with the expanded pixel on each phase-1 byte when `fwd`=1.
- Pixel counter (12 bit) increments per assembled pixel. On href falling edge:
  - If the pixel count ≠ `H_DISP` or the phase is 1 (dangling byte), set `err[0]`. A dangling byte is discarded.
  - Increment the line counter (12 bit, saturates at 4095), reset the pixel counter and the phase.
- At frame start, if the previous frame was forwarded:
  - Pulse `frame_done`.
  - Set `err[1]` if the line count ≠ `V_DISP`.
- `err` bits are set only during forwarded frames. They clear on reset or on a frame start with `enable`=0.
- `vs_o` pulses at frame start only when the new frame is forwarded.

## Timing
- Reset values: `vs_o`=0, `de_o`=0, `rgb_o`=0, `frame_done`=0, `err`=0. Also `run`=0, `fwd`=0, `skip_cnt`=`SKIP_FRAMES`, phase and counters 0.
- Latency: second byte at the pin in cycle n → s1 in cycle n+1 → `de_o`/`rgb_o` registered in cycle n+2.
- Vsync edge at the pin in cycle n → `vs_o` and `frame_done` high in cycle n+2, for exactly 1 cycle.
- Back-to-back pixels give `de_o` high every other cycle. `de_o` is never high in the same cycle as `vs_o`.
- Vsync edge while href is high: frame start takes priority. The partial line is dropped and no `err[0]` is set for it.
- `enable` falling mid-frame has no effect until the next frame start.
- `rst_n` asserted mid-line clears everything immediately. Output resumes only after a fresh frame start and the skip period.

## Test plan
- `SKIP_FRAMES`=2, `enable`=1, 4 frames of 4×2 (`H_DISP`=4, `V_DISP`=2) → frames 1–2 produce no `vs_o`/`de_o`. Frames 3–4 each give 1 `vs_o` and 8 `de_o`, `frame_done` at the following frame start, `err`=0.
- Byte pair 0xF8,0x1F → `rgb_o`=0xFF00FF. Pair 0x07,0xE0 → 0x00FF00. Pair 0x00,0x00 → 0x000000. Each appears 2 cycles after the second byte.
- Line with 7 bytes → 3 `de_o`, `err[0]`=1 sticky. Next frame started with `enable`=0 → `err`=0.
- Frame with 3 lines when `V_DISP`=2 → `err[1]`=1 at the next frame start, `frame_done` pulses.
- `enable` dropped mid-frame → current frame completes with all `de_o`. The next frame has no `vs_o`. Re-enable → `SKIP_FRAMES` frames are discarded again.
- `rst_n` pulsed low mid-line → all outputs 0 on the next sampled cycle. Streaming restarts after frame start plus skip.

Source files
------------

// File: rtl/dvp_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dvp_capture                                                   |
// | Purpose  : DVP camera bus capture; RGB565 byte pairs -> RGB888 stream    |
// |            with start-up frame skipping and line/frame length checks.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dvp_capture #(
  parameter int H_DISP      = 1280,
  parameter int V_DISP      = 720,
  parameter int SKIP_FRAMES = 10,
  parameter int VS_POL      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        enable,
  output logic        vs_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic        frame_done,
  output logic [1:0]  err
);

  localparam logic [11:0] c_h_disp = 12'(H_DISP);
  localparam logic [11:0] c_v_disp = 12'(V_DISP);
  localparam logic [7:0]  c_skip   = 8'(SKIP_FRAMES);

  // IDLE: capture disabled; SKIP: sensor settling; STREAM: frame forwarded
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        vs_s1_q, vs_s1_d, vs_s2_q;
  logic        href_s1_q, href_s1_d, href_s2_q;
  logic [7:0]  data_s1_q, data_s1_d;
  logic [7:0]  skip_cnt_q, skip_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic        drop_q, drop_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic [23:0] rgb_q, rgb_d;
  logic        fd_q, fd_d;
  logic [1:0]  err_q, err_d;

  logic frame_start;
  logic href_fall;
  logic fwd;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Next-state: input sampling, frame/line bookkeeping, pixel assembly
  always_comb begin
    vs_s1_d    = (VS_POL != 0) ? cam_vsync : ~cam_vsync;
    href_s1_d  = cam_href;
    data_s1_d  = cam_data;
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    drop_d     = drop_q;
    vs_d       = 1'b0;
    de_d       = 1'b0;
    rgb_d      = rgb_q;
    fd_d       = 1'b0;
    err_d      = err_q;

    frame_start = vs_s1_q & ~vs_s2_q;
    href_fall   = href_s2_q & ~href_s1_q;
    fwd         = (state_q == ST_STREAM);

    if (frame_start) begin
      // Close out the previous frame before deciding the fate of the new one
      if (fwd) begin
        fd_d = 1'b1;
        if (line_cnt_q != c_v_disp) err_d[1] = 1'b1;
      end
      phase_d    = 1'b0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      // A line already in progress at frame start is thrown away entirely
      drop_d     = href_s1_q;
      if (!enable) begin
        state_d    = ST_IDLE;
        skip_cnt_d = c_skip;
        err_d      = 2'b00;   // disabling wins over the end-of-frame check
      end else if (skip_cnt_q != 8'd0) begin
        state_d    = ST_SKIP;
        skip_cnt_d = skip_cnt_q - 8'd1;
      end else begin
        state_d = ST_STREAM;
        vs_d    = 1'b1;
      end
    end else if (href_fall) begin
      if (!drop_q) begin
        if (fwd && ((pix_cnt_q != c_h_disp) || phase_q)) err_d[0] = 1'b1;
        if (line_cnt_q != 12'hFFF) line_cnt_d = line_cnt_q + 12'd1;
      end
      drop_d    = 1'b0;
      pix_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (href_s1_q && !drop_q) begin
      if (!phase_q) begin
        hi_d    = data_s1_q;
        phase_d = 1'b1;
      end else begin
        phase_d   = 1'b0;
        pix_cnt_d = pix_cnt_q + 12'd1;
        if (fwd) begin
          de_d  = 1'b1;
          rgb_d = rgb565_to_888({hi_q, data_s1_q});
        end
      end
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vs_s1_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      href_s1_q  <= 1'b0;
      href_s2_q  <= 1'b0;
      data_s1_q  <= '0;
      skip_cnt_q <= c_skip;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      drop_q     <= 1'b0;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      rgb_q      <= '0;
      fd_q       <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      vs_s1_q    <= vs_s1_d;
      vs_s2_q    <= vs_s1_q;
      href_s1_q  <= href_s1_d;
      href_s2_q  <= href_s1_q;
      data_s1_q  <= data_s1_d;
      skip_cnt_q <= skip_cnt_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      drop_q     <= drop_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      rgb_q      <= rgb_d;
      fd_q       <= fd_d;
      err_q      <= err_d;
    end
  end

  assign vs_o       = vs_q;
  assign de_o       = de_q;
  assign rgb_o      = rgb_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dvp_capture                                                |
// | Purpose  : Directed, table-driven bench for dvp_capture (4x2 frames,     |
// |            two skipped frames after enable or reset).                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dvp_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        enable = 1'b0;
  logic        vs_o;
  logic        de_o;
  logic [23:0] rgb_o;
  logic        frame_done;
  logic [1:0]  err;

  dvp_capture #(
    .H_DISP(4), .V_DISP(2), .SKIP_FRAMES(2), .VS_POL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .enable(enable), .vs_o(vs_o), .de_o(de_o),
    .rgb_o(rgb_o), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int vs_cnt = 0, de_cnt = 0, fd_cnt = 0, clash_cnt = 0;
  logic [23:0] rgb_log[$];
  int          de_cyc_log[$];
  int          lo_cyc_log[$];
  logic [7:0]  line_buf[$];
  int v0, d0, f0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [23:0] exp_rgb;
  } vec_t;
  vec_t tbl[8];

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (vs_o) vs_cnt++;
    if (frame_done) fd_cnt++;
    if (de_o) begin
      de_cnt++;
      rgb_log.push_back(rgb_o);
      de_cyc_log.push_back(cyc);
    end
    if (vs_o && de_o) clash_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk);
    #1;
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_buf();
    for (int i = 0; i < line_buf.size(); i++) begin
      step(1'b0, 1'b1, line_buf[i]);
      if (i % 2 == 1) lo_cyc_log.push_back(cyc);
    end
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int nbytes);
    line_buf.delete();
    for (int i = 0; i < nbytes; i++) line_buf.push_back(8'(i * 3 + 1));
    send_buf();
  endtask

  task automatic snap();
    v0 = vs_cnt;
    d0 = de_cnt;
    f0 = fd_cnt;
  endtask

  task automatic frame_counts(input string tag, input int evs, input int ede, input int efd);
    chk({tag, " vs_o count"}, 32'(vs_cnt - v0), 32'(evs));
    chk({tag, " de_o count"}, 32'(de_cnt - d0), 32'(ede));
    chk({tag, " frame_done count"}, 32'(fd_cnt - f0), 32'(efd));
  endtask

  task automatic run_frame(input string tag, input int lines, input int nbytes,
                           input int evs, input int ede, input int efd);
    snap();
    vsync_pulse();
    for (int l = 0; l < lines; l++) send_line(nbytes);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    frame_counts(tag, evs, ede, efd);
  endtask

  initial begin
    tbl[0] = '{8'hF8, 8'h1F, 24'hFF00FF};
    tbl[1] = '{8'h07, 8'hE0, 24'h00FF00};
    tbl[2] = '{8'h00, 8'h00, 24'h000000};
    tbl[3] = '{8'hFF, 8'hFF, 24'hFFFFFF};
    tbl[4] = '{8'h08, 8'h41, 24'h080808};
    tbl[5] = '{8'h84, 8'h10, 24'h848284};
    tbl[6] = '{8'hF8, 8'h00, 24'hFF0000};
    tbl[7] = '{8'h7B, 8'hEF, 24'h7B7D7B};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset vs_o", 32'(vs_o), 32'd0);
    chk("reset de_o", 32'(de_o), 32'd0);
    chk("reset rgb_o", 32'(rgb_o), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    step(1'b0, 1'b0, 8'h00);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // Two settling frames are suppressed
    run_frame("f1", 2, 8, 0, 0, 0);
    run_frame("f2", 2, 8, 0, 0, 0);

    // Frame 3: table-driven colour conversion and latency
    snap();
    vsync_pulse();
    rgb_log.delete();
    de_cyc_log.delete();
    lo_cyc_log.delete();
    for (int l = 0; l < 2; l++) begin
      line_buf.delete();
      for (int p = 0; p < 4; p++) begin
        line_buf.push_back(tbl[l * 4 + p].hi);
        line_buf.push_back(tbl[l * 4 + p].lo);
      end
      send_buf();
    end
    repeat (4) step(1'b0, 1'b0, 8'h00);
    frame_counts("f3", 1, 8, 0);
    chk("f3 pixel log size", 32'(rgb_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < rgb_log.size() && i < lo_cyc_log.size()) begin
        chk($sformatf("rgb vec%0d", i), 32'(rgb_log[i]), 32'(tbl[i].exp_rgb));
        chk($sformatf("latency vec%0d", i), 32'(de_cyc_log[i]), 32'(lo_cyc_log[i] + 2));
      end
    end
    chk("rgb_o holds last pixel", 32'(rgb_o), 32'(tbl[7].exp_rgb));
    chk("f3 err", 32'(err), 32'd0);

    run_frame("f4", 2, 8, 1, 8, 1);
    chk("f4 err", 32'(err), 32'd0);

    // Frame 5: a 7-byte line gives 3 pixels and a sticky err[0]
    snap();
    vsync_pulse();
    send_line(7);
    send_line(8);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    frame_counts("f5", 1, 7, 1);
    chk("f5 err after short line", 32'(err), 32'd1);

    // Frame 6: three lines; err[0] remains set
    run_frame("f6", 3, 8, 1, 12, 1);
    chk("f6 err sticky", 32'(err), 32'd1);

    // Frame 7: err[1] from frame 6; enable dropped mid-frame
    snap();
    vsync_pulse();
    send_line(8);
    chk("f7 err line count", 32'(err), 32'd3);
    enable = 1'b0;
    send_line(8);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    frame_counts("f7", 1, 8, 1);

    // Frame 8: started with enable low
    run_frame("f8", 2, 8, 0, 0, 1);
    chk("f8 err cleared", 32'(err), 32'd0);

    // Re-enable: two frames skipped again
    enable = 1'b1;
    run_frame("f9", 2, 8, 0, 0, 0);
    run_frame("f10", 2, 8, 0, 0, 0);
    run_frame("f11", 2, 8, 1, 8, 0);

    // Frame 12: reset asserted mid-line
    vsync_pulse();
    send_line(8);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midline reset outputs", {7'd0, vs_o, de_o, rgb_o[22:0]}, 32'd0);
    chk("midline reset rgb msb/fd/err", {28'd0, rgb_o[23], frame_done, err}, 32'd0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);

    run_frame("f13", 2, 8, 0, 0, 0);
    run_frame("f14", 2, 8, 0, 0, 0);
    run_frame("f15", 2, 8, 1, 8, 0);
    run_frame("f16", 2, 8, 1, 8, 1);
    chk("f16 err", 32'(err), 32'd0);
    chk("vs_o/de_o overlap", 32'(clash_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
